ex_stage: RTL
=============

# ex_stage

Execute stage of the multi-cycle cached pipeline, directly downstream of the ID/EX register. It consumes decoded operands and control, computes ALU results, memory addresses and branch outcomes, and drives the registered EX/MEM pipeline outputs. An optional iterative 32-cycle multiplier stalls the front end while it runs. A memory-side stall (cache miss) freezes the stage.

## Interface
- Parameters: none. Widths are fixed at 32-bit data and 5-bit register index.
- clk  in  1  Clock, rising edge.
- reset  in  1  Synchronous, active-low reset (clears state when low at a rising edge).
- in_data_register_rs1 / in_data_register_rs2  in  32  Operand values.
- in_reg_rd  in  5  Destination register.
- in_alu_operation_type  in  4  ALU op (pkg encoding).
- in_alu_src_imm  in  1  Operand B = in_imm_i_type instead of rs2.
- in_write_register, in_load_word_memory, in_store_word_memory, in_branch, in_jump, in_panic  in  1  Control flags.
- in_branch_operation_type  in  4  Branch compare (pkg encoding).
- in_pc  in  32  PC of the instruction.
- in_imm_i_type / in_imm_s_type  in  32  Immediates; the branch/jump offset arrives in in_imm_i_type.
- in_stall_mem  in  1  Downstream freeze request.
- out_stall_ex  out  1  Combinational. Upstream must hold all in_* stable while high.
- out_alu_result  out  32  ALU result or effective address.
- out_store_data  out  32  rs2 pass-through.
- out_reg_rd  out  5; out_write_register, out_load_word_memory, out_store_word_memory, out_panic  out  1.
- out_branch_taken  out  1; out_branch_target  out  32.

## Operation
- ALU ops: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 MUL (low 32 bits).
  - Undefined ops give result 0.
  - Shifts use B[4:0].
- Loads: result = rs1 + imm_i. Stores: result = rs1 + imm_s. Both override the ALU op.
- Branch ops: 0 BEQ, 1 BNE, 2 BLT, 3 BGE, 4 BLTU, 5 BGEU. Undefined ops are not taken.
- taken = in_jump | (in_branch & cond). target = in_pc + in_imm_i_type, mod 2^32.
- Jump with in_write_register set writes in_pc + 4 to rd.
- in_panic passes through. A panic instruction performs no load, store or branch (flags forced to 0).
- FSM states: IDLE, BUSY, DONE.
  - IDLE → BUSY when the MUL op is presented and in_stall_mem = 0. Counter cleared, multiplicand and multiplier latched.
  - BUSY: one shift-add per cycle. At counter 31 → DONE.
  - DONE → IDLE on the next unfrozen edge, registering the product into EX/MEM.
- out_stall_ex = (IDLE & op==MUL) | BUSY. It is low in DONE.
- While out_stall_ex is high, EX/MEM receives a bubble: all control outputs 0, data held.
- in_stall_mem = 1 freezes everything: all outputs, FSM state, counter and partial product hold. out_stall_ex still reflects the current state.
- Simultaneous MUL and in_stall_mem in IDLE: remain in IDLE until in_stall_mem drops.
- Reset low at any edge, including mid-BUSY: FSM → IDLE, counter 0, all registered outputs 0. out_stall_ex then follows its equation.

## Timing
- Non-MUL ops: sampled at edge N, visible on outputs after edge N. One-cycle latency, one instruction per cycle.
- MUL: out_stall_ex high for 33 cycles (1 IDLE + 32 BUSY). Result on outputs after the edge ending DONE, i.e. 34 edges after first presentation, plus any frozen cycles.
- out_stall_ex is combinational from state and in_alu_operation_type. It has no dependency on in_stall_mem.

## Configuration
- EX_MUL_EN defined: multiplier and FSM present, as above.
- EX_MUL_EN undefined: no FSM. out_stall_ex is tied 0. Op 10 completes in one cycle with out_panic = 1, out_write_register = 0 and result 0.

## Structure
- Shared package ex_pkg holds:
  - ALU op and branch op localparam encodings;
  - FSM state enum;
  - XLEN = 32 and MUL_CYCLES = 32.
- One sub-module: ex_alu (combinational ALU, branch comparator, address adder). The FSM, multiplier datapath and EX/MEM registers stay in ex_stage.

## Test plan
- ADD: rs1 = 5, rs2 = 7, op 0, write = 1, rd = 3 → next cycle out_alu_result = 12, out_reg_rd = 3, out_write_register = 1.
- Load: rs1 = 0x100, imm_i = 0xFFFFFFFC, load = 1 → out_alu_result = 0xFC, out_load_word_memory = 1. Store with imm_s = 8 → 0x108, out_store_data = rs2.
- BLT: rs1 = 0xFFFFFFFF, rs2 = 1, pc = 0x40, imm = 0x10 → taken = 1, target = 0x50. BLTU with the same operands → taken = 0.
- MUL (EX_MUL_EN): 0xFFFF × 0x10001 → out_stall_ex high for exactly 33 cycles, bubbles on outputs, then out_alu_result = 0xFFFFFFFF. Without EX_MUL_EN → out_panic = 1 in one cycle.
- in_stall_mem pulsed for 3 cycles mid-BUSY → stall lengthens by 3 cycles and the product is still correct. in_stall_mem asserted on an ADD → outputs hold the previous values.
- Reset low during BUSY at cycle 10 → next cycle all outputs 0, FSM in IDLE. A subsequent MUL restarts with full 33-cycle stall.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: widths, ALU/branch op
// encodings and the multiplier FSM state type.
package ex_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned MUL_CYCLES = 32;
    localparam int unsigned CNT_W      = $clog2(MUL_CYCLES);

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;
    localparam logic [3:0] ALU_MUL  = 4'd10;

    localparam logic [3:0] BR_BEQ  = 4'd0;
    localparam logic [3:0] BR_BNE  = 4'd1;
    localparam logic [3:0] BR_BLT  = 4'd2;
    localparam logic [3:0] BR_BGE  = 4'd3;
    localparam logic [3:0] BR_BLTU = 4'd4;
    localparam logic [3:0] BR_BGEU = 4'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } ex_state_t;

endpackage

// File: rtl/ex_alu.sv
// Combinational ALU, branch comparator and address/target adders.
// The MUL op yields 0 here; the multiplier lives in ex_stage.
module ex_alu
    import ex_pkg::*;
(
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic [31:0] imm_i,
    input  logic [31:0] imm_s,
    input  logic [31:0] pc,
    input  logic [3:0]  alu_op,
    input  logic [3:0]  branch_op,
    input  logic        alu_src_imm,
    input  logic        load,
    input  logic        store,
    input  logic        jump,
    output logic [31:0] result,
    output logic [31:0] target,
    output logic        branch_cond
);

    logic [31:0] op_b;

    assign op_b   = alu_src_imm ? imm_i : rs2;
    assign target = pc + imm_i;

    // Result select: jump link, load/store address, else the ALU op
    always_comb begin
        result = '0;
        if (jump) begin
            result = pc + 32'd4;
        end else if (load) begin
            result = rs1 + imm_i;
        end else if (store) begin
            result = rs1 + imm_s;
        end else begin
            case (alu_op)
                ALU_ADD:  result = rs1 + op_b;
                ALU_SUB:  result = rs1 - op_b;
                ALU_AND:  result = rs1 & op_b;
                ALU_OR:   result = rs1 | op_b;
                ALU_XOR:  result = rs1 ^ op_b;
                ALU_SLL:  result = rs1 << op_b[4:0];
                ALU_SRL:  result = rs1 >> op_b[4:0];
                ALU_SRA:  result = $signed(rs1) >>> op_b[4:0];
                ALU_SLT:  result = {31'd0, $signed(rs1) < $signed(op_b)};
                ALU_SLTU: result = {31'd0, rs1 < op_b};
                default:  result = '0;
            endcase
        end
    end

    // Branch condition on rs1 vs rs2; undefined compares are never taken
    always_comb begin
        branch_cond = 1'b0;
        case (branch_op)
            BR_BEQ:  branch_cond = (rs1 == rs2);
            BR_BNE:  branch_cond = (rs1 != rs2);
            BR_BLT:  branch_cond = ($signed(rs1) <  $signed(rs2));
            BR_BGE:  branch_cond = ($signed(rs1) >= $signed(rs2));
            BR_BLTU: branch_cond = (rs1 <  rs2);
            BR_BGEU: branch_cond = (rs1 >= rs2);
            default: branch_cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU/branch via ex_alu, EX/MEM output registers and,
// when EX_MUL_EN is defined, a 32-cycle shift-add multiplier that stalls
// the front end. Without EX_MUL_EN the MUL op raises panic.
module ex_stage
    import ex_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_data_register_rs1,
    input  logic [31:0] in_data_register_rs2,
    input  logic [4:0]  in_reg_rd,
    input  logic [3:0]  in_alu_operation_type,
    input  logic        in_alu_src_imm,
    input  logic        in_write_register,
    input  logic        in_load_word_memory,
    input  logic        in_store_word_memory,
    input  logic        in_branch,
    input  logic        in_jump,
    input  logic        in_panic,
    input  logic [3:0]  in_branch_operation_type,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_imm_i_type,
    input  logic [31:0] in_imm_s_type,
    input  logic        in_stall_mem,
    output logic        out_stall_ex,
    output logic [31:0] out_alu_result,
    output logic [31:0] out_store_data,
    output logic [4:0]  out_reg_rd,
    output logic        out_write_register,
    output logic        out_load_word_memory,
    output logic        out_store_word_memory,
    output logic        out_panic,
    output logic        out_branch_taken,
    output logic [31:0] out_branch_target
);

    logic [31:0] alu_result;
    logic [31:0] branch_target;
    logic        branch_cond;
    logic [31:0] next_result;
    logic        next_write;
    logic        next_panic;

    ex_alu u_alu (
        .rs1         (in_data_register_rs1),
        .rs2         (in_data_register_rs2),
        .imm_i       (in_imm_i_type),
        .imm_s       (in_imm_s_type),
        .pc          (in_pc),
        .alu_op      (in_alu_operation_type),
        .branch_op   (in_branch_operation_type),
        .alu_src_imm (in_alu_src_imm),
        .load        (in_load_word_memory),
        .store       (in_store_word_memory),
        .jump        (in_jump),
        .result      (alu_result),
        .target      (branch_target),
        .branch_cond (branch_cond)
    );

`ifdef EX_MUL_EN
    ex_state_t        state;
    logic [CNT_W-1:0] count;
    logic [31:0]      mcand;
    logic [31:0]      mplier;
    logic [31:0]      product;
    logic [31:0]      mul_b;

    assign mul_b        = in_alu_src_imm ? in_imm_i_type : in_data_register_rs2;
    assign out_stall_ex = ((state == IDLE) && (in_alu_operation_type == ALU_MUL))
                        || (state == BUSY);

    // Multiplier FSM and shift-add datapath; frozen by in_stall_mem
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            count   <= '0;
            mcand   <= '0;
            mplier  <= '0;
            product <= '0;
        end else if (!in_stall_mem) begin
            case (state)
                IDLE: begin
                    if (in_alu_operation_type == ALU_MUL) begin
                        state   <= BUSY;
                        count   <= '0;
                        mcand   <= in_data_register_rs1;
                        mplier  <= mul_b;
                        product <= '0;
                    end
                end
                BUSY: begin
                    if (mplier[0]) begin
                        product <= product + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                    if (count == CNT_W'(MUL_CYCLES - 1)) begin
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // In DONE the finished product replaces the (zero) ALU result
    always_comb begin
        next_result = alu_result;
        next_write  = in_write_register;
        next_panic  = in_panic;
        if (state == DONE) begin
            next_result = product;
        end
    end
`else
    assign out_stall_ex = 1'b0;

    // MUL is unsupported in this build: trap it as a panic with no writeback
    always_comb begin
        next_result = alu_result;
        next_write  = in_write_register;
        next_panic  = in_panic;
        if (in_alu_operation_type == ALU_MUL) begin
            next_result = '0;
            next_write  = 1'b0;
            next_panic  = 1'b1;
        end
    end
`endif

    // EX/MEM register: bubble while stalling, hold everything when frozen
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_alu_result        <= '0;
            out_store_data        <= '0;
            out_reg_rd            <= '0;
            out_write_register    <= 1'b0;
            out_load_word_memory  <= 1'b0;
            out_store_word_memory <= 1'b0;
            out_panic             <= 1'b0;
            out_branch_taken      <= 1'b0;
            out_branch_target     <= '0;
        end else if (!in_stall_mem) begin
            if (out_stall_ex) begin
                out_write_register    <= 1'b0;
                out_load_word_memory  <= 1'b0;
                out_store_word_memory <= 1'b0;
                out_panic             <= 1'b0;
                out_branch_taken      <= 1'b0;
            end else begin
                out_alu_result        <= next_result;
                out_store_data        <= in_data_register_rs2;
                out_reg_rd            <= in_reg_rd;
                out_write_register    <= next_write;
                out_load_word_memory  <= in_load_word_memory & ~next_panic;
                out_store_word_memory <= in_store_word_memory & ~next_panic;
                out_panic             <= next_panic;
                out_branch_taken      <= (in_jump | (in_branch & branch_cond)) & ~next_panic;
                out_branch_target     <= branch_target;
            end
        end
    end

endmodule
